fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controls the fetch stage of the pipelined MIPS core.
- Generates the PC enable and next-PC select, plus the IF/ID enable/flush and ID/EX flush.
- Detects load-use hazards, applies taken-branch/jump redirects, and sequences a req/ack instruction-memory handshake with timeout.
- Handles halt/resume.
- Sits between the hazard sources (ID/EX stage fields, branch resolve, IMEM) and the PC register plus IF/ID and ID/EX pipeline registers.

Parameters:
RW, 5, register-specifier width
CW, 16, stall counter width
TIMEOUT, 64, max IMEM wait cycles before error (>=2)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
ID_RS  in  RW  rs of instruction in ID
ID_RT  in  RW  rt of instruction in ID
EX_MEMREAD  in  1  instruction in EX is a load
EX_RT  in  RW  destination rt of instruction in EX
BRANCH_TAKEN  in  1  branch in ID resolved taken
JUMP  in  1  jump in ID
IMEM_ACK  in  1  instruction word valid this cycle
HALT_IN  in  1  halt request (syscall/break)
RESUME  in  1  leave HALTED
PC_EN  out  1  PC register load enable
PC_SEL  out  2  0=PC+1, 1=branch target, 2=jump target
IFID_EN  out  1  IF/ID load enable
IFID_FLUSH  out  1  IF/ID loads bubble
IDEX_FLUSH  out  1  ID/EX loads bubble
IMEM_REQ  out  1  fetch request
STATE  out  3  current state encoding
STALL_CNT  out  CW  count of stall cycles, saturating
ERR  out  1  IMEM timeout, sticky until RST

Behaviour:
- State encoding: RUN=0, IWAIT=1, HALTED=2.
- All outputs are combinational from state and inputs. STALL_CNT, ERR and the internal WAIT_CNT are registered.
- Defaults (any state, unless overridden below): PC_EN=0, PC_SEL=0, IFID_EN=1, IFID_FLUSH=0, IDEX_FLUSH=0, IMEM_REQ=1.
- RST high at a clock edge: state=RUN, STALL_CNT=0, ERR=0, WAIT_CNT=0. RST has priority over everything, including mid-wait and HALTED.
- lu = EX_MEMREAD && EX_RT!=0 && (EX_RT==ID_RS || EX_RT==ID_RT).
- redir = BRANCH_TAKEN || JUMP. PC_SEL on a redirect = 1 if BRANCH_TAKEN, else 2 (branch wins when both are high).
- RUN, evaluated in priority order:
  1. HALT_IN: IFID_FLUSH=1; next=HALTED.
  2. lu: PC_EN=0, IFID_EN=0, IDEX_FLUSH=1; redir is ignored this cycle and re-evaluated next cycle; stay RUN.
  3. redir: PC_EN=1, PC_SEL as above, IFID_FLUSH=1; stay RUN.
  4. !IMEM_ACK: IFID_FLUSH=1; WAIT_CNT<=1; next=IWAIT.
  5. otherwise: PC_EN=1, PC_SEL=0.
- IWAIT, evaluated in priority order:
  1. HALT_IN: as in RUN.
  2. lu: IFID_EN=0, IDEX_FLUSH=1; WAIT_CNT still advances.
  3. redir: PC_EN=1, PC_SEL as above, IFID_FLUSH=1; next=RUN (the outstanding fetch is abandoned).
  4. IMEM_ACK: PC_EN=1, PC_SEL=0; next=RUN.
  5. WAIT_CNT==TIMEOUT-1: ERR<=1; next=HALTED.
  6. otherwise: IFID_FLUSH=1; WAIT_CNT++.
- HALTED: IMEM_REQ=0, IFID_EN=0. RESUME && !ERR -> next=RUN. RESUME is ignored while ERR=1.
- STALL_CNT increments on every cycle where PC_EN=0 and state!=HALTED. It saturates at all-ones and never wraps.
- Register $0 never triggers lu. rs and rt matching the same EX_RT counts as one stall.
- A load-use stall lasts exactly 1 cycle when EX advances normally.
- Redirect latency: the PC loads the target on the same edge; one bubble enters IF/ID.

Test Plan:
- Load-use: RST 2 cycles; run with IMEM_ACK=1; EX_MEMREAD=1, EX_RT=5, ID_RS=5 for 1 cycle -> PC_EN=0, IFID_EN=0, IDEX_FLUSH=1 that cycle, STALL_CNT=1. Repeat with EX_RT=0 -> no stall.
- Redirect priority: BRANCH_TAKEN=1 and JUMP=1 together -> PC_EN=1, PC_SEL=1, IFID_FLUSH=1. JUMP alone -> PC_SEL=2. lu with BRANCH_TAKEN together -> stall, PC_EN=0.
- IMEM wait: IMEM_ACK=0 for 3 cycles then 1 -> STATE=1 for 3 cycles, IFID_FLUSH=1 each cycle, PC_EN=1 with PC_SEL=0 on the ack cycle, STALL_CNT=3, STATE=0 after.
- Timeout: TIMEOUT=4, IMEM_ACK held 0 -> ERR=1 on the 4th wait edge, STATE=2, IMEM_REQ=0. RESUME=1 -> stays HALTED. RST -> ERR=0, STATE=0.
- Halt/resume: HALT_IN pulse in RUN -> IFID_FLUSH=1, then STATE=2, PC_EN=0, STALL_CNT unchanged over 10 cycles. RESUME -> STATE=0 next cycle.
- Saturation/reset mid-op: CW=3, force 9 stall cycles -> STALL_CNT=7. RST asserted during IWAIT -> STATE=0, STALL_CNT=0, WAIT_CNT=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Fetch-stage controller for the pipelined MIPS core. It decides each cycle
// whether the PC loads and from which source, whether IF/ID holds, loads or
// takes a bubble, and whether ID/EX takes a bubble. It detects load-use
// hazards, applies taken-branch/jump redirects, runs the req/ack handshake
// with the instruction memory (with a timeout), and handles halt/resume.
//
// Ports
//   CLK, RST        clock (rising edge), synchronous active-high reset
//   ID_RS, ID_RT    source registers of the instruction in ID
//   EX_MEMREAD      instruction in EX is a load
//   EX_RT           destination register of the instruction in EX
//   BRANCH_TAKEN    branch in ID resolved taken
//   JUMP            jump in ID
//   IMEM_ACK        instruction word valid this cycle
//   HALT_IN         halt request (syscall/break)
//   RESUME          leave HALTED (ignored while ERR is set)
//   PC_EN           PC register load enable
//   PC_SEL          next-PC select: 0=PC+1, 1=branch target, 2=jump target
//   IFID_EN         IF/ID load enable
//   IFID_FLUSH      IF/ID loads a bubble
//   IDEX_FLUSH      ID/EX loads a bubble
//   IMEM_REQ        fetch request to instruction memory
//   STATE           current state: 0=RUN, 1=IWAIT, 2=HALTED
//   STALL_CNT       saturating count of cycles the PC did not advance
//   ERR             instruction-memory timeout, sticky until RST
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int RW      = 5,
  parameter int CW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [RW-1:0] ID_RS,
  input  logic [RW-1:0] ID_RT,
  input  logic          EX_MEMREAD,
  input  logic [RW-1:0] EX_RT,
  input  logic          BRANCH_TAKEN,
  input  logic          JUMP,
  input  logic          IMEM_ACK,
  input  logic          HALT_IN,
  input  logic          RESUME,
  output logic          PC_EN,
  output logic [1:0]    PC_SEL,
  output logic          IFID_EN,
  output logic          IFID_FLUSH,
  output logic          IDEX_FLUSH,
  output logic          IMEM_REQ,
  output logic [2:0]    STATE,
  output logic [CW-1:0] STALL_CNT,
  output logic          ERR
);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    IWAIT  = 3'd1,
    HALTED = 3'd2
  } state_t;

  // The wait counter only ever needs to reach TIMEOUT-1.
  localparam int            WW        = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  localparam logic [1:0] SEL_SEQ    = 2'd0;
  localparam logic [1:0] SEL_BRANCH = 2'd1;
  localparam logic [1:0] SEL_JUMP   = 2'd2;

  state_t        state;
  state_t        state_nxt;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_nxt;
  logic          err_set;

  logic          load_use;
  logic          redir;
  logic [1:0]    redir_sel;

  // Register $0 is hardwired to zero, so a load "into" it never creates a
  // dependency. A match on rs and rt together is still a single stall.
  assign load_use  = EX_MEMREAD && (EX_RT != '0) &&
                     ((EX_RT == ID_RS) || (EX_RT == ID_RT));
  assign redir     = BRANCH_TAKEN || JUMP;
  // Branch wins over jump when both are asserted.
  assign redir_sel = BRANCH_TAKEN ? SEL_BRANCH : SEL_JUMP;

  assign STATE = state;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    PC_EN      = 1'b0;
    PC_SEL     = SEL_SEQ;
    IFID_EN    = 1'b1;
    IFID_FLUSH = 1'b0;
    IDEX_FLUSH = 1'b0;
    IMEM_REQ   = 1'b1;
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    err_set    = 1'b0;

    case (state)
      RUN: begin
        if (HALT_IN) begin
          IFID_FLUSH = 1'b1;
          state_nxt  = HALTED;
        end else if (load_use) begin
          // Hold PC and IF/ID, bubble into EX; a pending redirect is simply
          // seen again next cycle once the hazard has cleared.
          IFID_EN    = 1'b0;
          IDEX_FLUSH = 1'b1;
        end else if (redir) begin
          PC_EN      = 1'b1;
          PC_SEL     = redir_sel;
          IFID_FLUSH = 1'b1;
        end else if (!IMEM_ACK) begin
          IFID_FLUSH = 1'b1;
          wait_nxt   = WW'(1);
          state_nxt  = IWAIT;
        end else begin
          PC_EN = 1'b1;
        end
      end

      IWAIT: begin
        if (HALT_IN) begin
          IFID_FLUSH = 1'b1;
          state_nxt  = HALTED;
        end else if (load_use) begin
          IFID_EN    = 1'b0;
          IDEX_FLUSH = 1'b1;
          // Keep counting the wait, but never step past the deadline so the
          // timeout still fires once the hazard clears.
          if (wait_cnt != WAIT_LAST) begin
            wait_nxt = wait_cnt + WW'(1);
          end
        end else if (redir) begin
          // The outstanding fetch is abandoned in favour of the target.
          PC_EN      = 1'b1;
          PC_SEL     = redir_sel;
          IFID_FLUSH = 1'b1;
          state_nxt  = RUN;
        end else if (IMEM_ACK) begin
          PC_EN     = 1'b1;
          state_nxt = RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          err_set   = 1'b1;
          state_nxt = HALTED;
        end else begin
          IFID_FLUSH = 1'b1;
          wait_nxt   = wait_cnt + WW'(1);
        end
      end

      HALTED: begin
        IMEM_REQ = 1'b0;
        IFID_EN  = 1'b0;
        // A timeout can only be cleared by reset.
        if (RESUME && !ERR) begin
          state_nxt = RUN;
        end
      end

      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      wait_cnt  <= '0;
      STALL_CNT <= '0;
      ERR       <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (err_set) begin
        ERR <= 1'b1;
      end
      // Cycles spent halted are deliberate, not stalls.
      if (!PC_EN && (state != HALTED) && (STALL_CNT != '1)) begin
        STALL_CNT <= STALL_CNT + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer, built with a narrow stall counter
// (CW=3) and a short IMEM timeout (TIMEOUT=4) so saturation and timeout are
// reached quickly. Inputs change 1 time unit after the rising edge, outputs
// are compared 2 units later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int RW      = 5;
  localparam int CW      = 3;
  localparam int TIMEOUT = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [RW-1:0] ID_RS, ID_RT, EX_RT;
  logic          EX_MEMREAD, BRANCH_TAKEN, JUMP, IMEM_ACK, HALT_IN, RESUME;
  logic          PC_EN, IFID_EN, IFID_FLUSH, IDEX_FLUSH, IMEM_REQ, ERR;
  logic [1:0]    PC_SEL;
  logic [2:0]    STATE;
  logic [CW-1:0] STALL_CNT;
  logic [6:0]    ctl_now;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_sequencer #(.RW(RW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ID_RS       (ID_RS),
    .ID_RT       (ID_RT),
    .EX_MEMREAD  (EX_MEMREAD),
    .EX_RT       (EX_RT),
    .BRANCH_TAKEN(BRANCH_TAKEN),
    .JUMP        (JUMP),
    .IMEM_ACK    (IMEM_ACK),
    .HALT_IN     (HALT_IN),
    .RESUME      (RESUME),
    .PC_EN       (PC_EN),
    .PC_SEL      (PC_SEL),
    .IFID_EN     (IFID_EN),
    .IFID_FLUSH  (IFID_FLUSH),
    .IDEX_FLUSH  (IDEX_FLUSH),
    .IMEM_REQ    (IMEM_REQ),
    .STATE       (STATE),
    .STALL_CNT   (STALL_CNT),
    .ERR         (ERR)
  );

  always #5 CLK = ~CLK;

  // Control outputs bundled as {PC_EN, PC_SEL, IFID_EN, IFID_FLUSH, IDEX_FLUSH, IMEM_REQ}.
  assign ctl_now = {PC_EN, PC_SEL, IFID_EN, IFID_FLUSH, IDEX_FLUSH, IMEM_REQ};

  function automatic logic [6:0] ctl(bit pc_en, int sel, bit ifid_en, bit fl, bit idf, bit req);
    return {pc_en, 2'(sel), ifid_en, fl, idf, req};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    ID_RS = '0; ID_RT = '0; EX_RT = '0; EX_MEMREAD = 1'b0;
    BRANCH_TAKEN = 1'b0; JUMP = 1'b0; IMEM_ACK = 1'b1;
    HALT_IN = 1'b0; RESUME = 1'b0;
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    idle();
    repeat (n) tick();
    RST = 1'b0;
  endtask

  // ---------------- table-driven vectors, all applied from RUN ------------
  typedef struct {
    logic [RW-1:0] rs, rt, ex_rt;
    logic          mr, br, jp, ack, halt;
    logic [6:0]    exp_ctl;
    int            exp_state;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  function automatic vec_t mkv(int rs, int rt, int mr, int ex_rt, int br, int jp,
                               int ack, int halt, logic [6:0] c, int ns);
    vec_t v;
    v.rs = RW'(rs); v.rt = RW'(rt); v.ex_rt = RW'(ex_rt);
    v.mr = (mr != 0); v.br = (br != 0); v.jp = (jp != 0);
    v.ack = (ack != 0); v.halt = (halt != 0);
    v.exp_ctl = c; v.exp_state = ns;
    return v;
  endfunction

  // ---------------- behavioural reference model --------------------------
  int m_state, m_wait, m_stall;
  bit m_err;

  task automatic model_eval(output logic [6:0] c, output int ns, output int nw,
                            output bit set_err, output bit stall_inc);
    bit pe, ie, fl, idf, req, lu;
    int sel;
    lu  = EX_MEMREAD && (EX_RT != 0) && (EX_RT == ID_RS || EX_RT == ID_RT);
    pe = 0; sel = 0; ie = 1; fl = 0; idf = 0; req = 1;
    ns = m_state; nw = m_wait; set_err = 0;
    if (m_state == 2) begin
      req = 0; ie = 0;
      if (RESUME && !m_err) ns = 0;
    end else if (HALT_IN) begin
      fl = 1; ns = 2;
    end else if (lu) begin
      ie = 0; idf = 1;
      if (m_state == 1) nw = (m_wait + 1 > TIMEOUT - 1) ? TIMEOUT - 1 : m_wait + 1;
    end else if (BRANCH_TAKEN || JUMP) begin
      pe = 1; sel = BRANCH_TAKEN ? 1 : 2; fl = 1; ns = 0;
    end else if (m_state == 0) begin
      if (IMEM_ACK) pe = 1;
      else begin fl = 1; nw = 1; ns = 1; end
    end else if (IMEM_ACK) begin
      pe = 1; ns = 0;
    end else if (m_wait == TIMEOUT - 1) begin
      set_err = 1; ns = 2;
    end else begin
      fl = 1; nw = m_wait + 1;
    end
    stall_inc = !pe && (m_state != 2);
    c = ctl(pe, sel, ie, fl, idf, req);
  endtask

  initial begin
    logic [6:0] e_ctl;
    int         e_ns, e_nw;
    bit         e_err, e_inc;

    RST = 1'b1;
    idle();

    vecs[0]  = mkv(1, 2, 0, 0, 0, 0, 1, 0, ctl(1, 0, 1, 0, 0, 1), 0); // plain fetch
    vecs[1]  = mkv(5, 2, 1, 5, 0, 0, 1, 0, ctl(0, 0, 0, 0, 1, 1), 0); // lu on rs
    vecs[2]  = mkv(0, 3, 1, 0, 0, 0, 1, 0, ctl(1, 0, 1, 0, 0, 1), 0); // $0 never stalls
    vecs[3]  = mkv(4, 7, 1, 7, 0, 0, 1, 0, ctl(0, 0, 0, 0, 1, 1), 0); // lu on rt
    vecs[4]  = mkv(6, 6, 1, 6, 0, 0, 1, 0, ctl(0, 0, 0, 0, 1, 1), 0); // rs and rt both
    vecs[5]  = mkv(5, 2, 0, 5, 0, 0, 1, 0, ctl(1, 0, 1, 0, 0, 1), 0); // match, not a load
    vecs[6]  = mkv(1, 2, 0, 0, 1, 1, 1, 0, ctl(1, 1, 1, 1, 0, 1), 0); // branch beats jump
    vecs[7]  = mkv(1, 2, 0, 0, 0, 1, 1, 0, ctl(1, 2, 1, 1, 0, 1), 0); // jump alone
    vecs[8]  = mkv(5, 2, 1, 5, 1, 0, 1, 0, ctl(0, 0, 0, 0, 1, 1), 0); // lu beats branch
    vecs[9]  = mkv(5, 2, 1, 5, 1, 0, 1, 1, ctl(0, 0, 1, 1, 0, 1), 2); // halt beats all
    vecs[10] = mkv(1, 2, 0, 0, 0, 0, 0, 0, ctl(0, 0, 1, 1, 0, 1), 1); // no ack -> IWAIT
    vecs[11] = mkv(1, 2, 0, 0, 0, 1, 0, 0, ctl(1, 2, 1, 1, 0, 1), 0); // jump beats no-ack
    vecs[12] = mkv(5, 2, 1, 5, 0, 0, 0, 0, ctl(0, 0, 0, 0, 1, 1), 0); // lu beats no-ack

    for (int i = 0; i < NV; i++) begin
      do_reset(1);
      ID_RS = vecs[i].rs; ID_RT = vecs[i].rt; EX_RT = vecs[i].ex_rt;
      EX_MEMREAD = vecs[i].mr; BRANCH_TAKEN = vecs[i].br; JUMP = vecs[i].jp;
      IMEM_ACK = vecs[i].ack; HALT_IN = vecs[i].halt;
      settle();
      check($sformatf("vec%0d ctl", i), 32'(ctl_now), 32'(vecs[i].exp_ctl));
      tick();
      check($sformatf("vec%0d state", i), 32'(STATE), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d stall_cnt", i), 32'(STALL_CNT), vecs[i].exp_ctl[6] ? 32'd0 : 32'd1);
    end

    // ---------------- load-use after a 2-cycle reset --------------------
    do_reset(2);
    check("reset state", 32'(STATE), 32'd0);
    check("reset stall_cnt", 32'(STALL_CNT), 32'd0);
    check("reset err", 32'(ERR), 32'd0);
    EX_MEMREAD = 1'b1; EX_RT = 5'd5; ID_RS = 5'd5;
    settle();
    check("lu ctl", 32'(ctl_now), 32'(ctl(0, 0, 0, 0, 1, 1)));
    tick();
    check("lu stall_cnt", 32'(STALL_CNT), 32'd1);
    EX_RT = 5'd0; ID_RS = 5'd0;
    settle();
    check("lu r0 ctl", 32'(ctl_now), 32'(ctl(1, 0, 1, 0, 0, 1)));
    tick();
    check("lu r0 stall_cnt", 32'(STALL_CNT), 32'd1);

    // ---------------- IMEM wait of 3 cycles ------------------------------
    do_reset(1);
    IMEM_ACK = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("iwait flush c%0d", k), 32'({PC_EN, IFID_FLUSH}), 32'b01);
      tick();
      check($sformatf("iwait state c%0d", k), 32'(STATE), 32'd1);
    end
    IMEM_ACK = 1'b1;
    settle();
    check("iwait ack ctl", 32'(ctl_now), 32'(ctl(1, 0, 1, 0, 0, 1)));
    tick();
    check("iwait exit state", 32'(STATE), 32'd0);
    check("iwait stall_cnt", 32'(STALL_CNT), 32'd3);

    // ---------------- timeout, resume ignored, reset clears --------------
    do_reset(1);
    IMEM_ACK = 1'b0;
    repeat (3) tick();
    check("timeout pre err", 32'({STATE, ERR}), 32'({3'd1, 1'b0}));
    tick();
    check("timeout err", 32'({STATE, ERR}), 32'({3'd2, 1'b1}));
    settle();
    check("timeout imem_req", 32'(IMEM_REQ), 32'd0);
    RESUME = 1'b1;
    repeat (2) tick();
    check("timeout resume ignored", 32'({STATE, ERR}), 32'({3'd2, 1'b1}));
    do_reset(1);
    check("timeout reset", 32'({STATE, ERR}), 32'({3'd0, 1'b0}));

    // ---------------- halt / resume --------------------------------------
    do_reset(1);
    HALT_IN = 1'b1;
    settle();
    check("halt flush", 32'(IFID_FLUSH), 32'd1);
    tick();
    HALT_IN = 1'b0;
    check("halt state", 32'(STATE), 32'd2);
    repeat (10) tick();
    settle();
    check("halted ctl", 32'(ctl_now), 32'(ctl(0, 0, 0, 0, 0, 0)));
    check("halted stall_cnt", 32'(STALL_CNT), 32'd1);
    RESUME = 1'b1;
    tick();
    RESUME = 1'b0;
    check("resume state", 32'(STATE), 32'd0);

    // ---------------- stall counter saturation ---------------------------
    do_reset(1);
    EX_MEMREAD = 1'b1; EX_RT = 5'd9; ID_RT = 5'd9;
    repeat (9) tick();
    check("saturate stall_cnt", 32'(STALL_CNT), 32'd7);

    // ---------------- reset in the middle of IWAIT -----------------------
    do_reset(1);
    IMEM_ACK = 1'b0;
    repeat (2) tick();
    check("mid-wait state", 32'(STATE), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mid-wait reset", 32'({STATE, STALL_CNT, ERR}), 32'd0);
    repeat (3) tick();
    check("post-reset wait err", 32'(ERR), 32'd0);
    tick();
    check("post-reset timeout", 32'({STATE, ERR}), 32'({3'd2, 1'b1}));

    // ---------------- randomized run against the model -------------------
    do_reset(1);
    m_state = 0; m_wait = 0; m_stall = 0; m_err = 0;
    for (int n = 0; n < 3000; n++) begin
      RST          = ($urandom_range(0, 39) == 0);
      ID_RS        = RW'($urandom_range(0, 3));
      ID_RT        = RW'($urandom_range(0, 3));
      EX_RT        = RW'($urandom_range(0, 3));
      EX_MEMREAD   = ($urandom_range(0, 3) == 0);
      BRANCH_TAKEN = ($urandom_range(0, 5) == 0);
      JUMP         = ($urandom_range(0, 5) == 0);
      IMEM_ACK     = ($urandom_range(0, 9) < 6);
      HALT_IN      = ($urandom_range(0, 19) == 0);
      RESUME       = ($urandom_range(0, 3) == 0);
      settle();
      model_eval(e_ctl, e_ns, e_nw, e_err, e_inc);
      check($sformatf("rand%0d", n), 32'({ctl_now, STATE, STALL_CNT, ERR}),
            32'({e_ctl, 3'(m_state), CW'(m_stall), m_err}));
      tick();
      if (RST) begin
        m_state = 0; m_wait = 0; m_stall = 0; m_err = 0;
      end else begin
        m_state = e_ns;
        m_wait  = e_nw;
        if (e_err) m_err = 1;
        if (e_inc && m_stall < (1 << CW) - 1) m_stall++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
